// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: pointer/count width helper
// and the packed status bundle.
package fifo_pkg;

    // One extra bit beyond the address width carries the wrap indication.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/param_sync_fifo_mem.sv
// Storage array for param_sync_fifo: synchronous write, read either registered
// (cleared when not reading) or asynchronous for first-word-fall-through.
module param_sync_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int FWFT   = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_rd
            logic unused_rd_ctl;
            assign unused_rd_ctl = rst ^ re;
            assign rdata = mem[raddr];
        end else begin : g_reg_rd
            // Output register returns to zero on every cycle without a pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end else begin
                    rdata <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through, occupancy count,
// almost-full/almost-empty thresholds, write-through-when-full, flush and sticky errors.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int CW       = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              winc,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rinc,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wfull,
    output logic              rempty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = CW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
        $error("param_sync_fifo: thresholds must satisfy 0 < AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic              ovf_flag;
    logic              udf_flag;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] mem_rdata;
    fifo_status_t      status;

    always_comb begin
        status.rempty       = (wr_ptr == rd_ptr);
        status.wfull        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        status.almost_full  = (count >= CW'(AFULL_TH));
        status.almost_empty = (count <= CW'(AEMPTY_TH));
        status.overflow     = ovf_flag;
        status.underflow    = udf_flag;
    end

    assign wfull        = status.wfull;
    assign rempty       = status.rempty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign rd_acc = rinc & ~status.rempty;
    assign wr_acc = winc & (~status.wfull | rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
            count <= count + CW'(wr_acc) - CW'(rd_acc);
            if (winc & ~wr_acc)        ovf_flag <= 1'b1;
            if (rinc & status.rempty)  udf_flag <= 1'b1;
        end
    end

    param_sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_acc & ~flush),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = status.rempty ? '0 : mem_rdata;
            assign rvalid = ~status.rempty;
        end else begin : g_registered
            assign rdata = mem_rdata;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc & ~flush;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised scoreboard bench for param_sync_fifo (registered-read instance) plus a
// directed first-word-fall-through instance.
module tb_param_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, winc = 1'b0, rinc = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        rvalid, wfull, rempty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        f_flush = 1'b0, f_winc = 1'b0, f_rinc = 1'b0;
    logic [15:0] f_wdata = '0;
    logic [15:0] f_rdata;
    logic        f_rvalid, f_wfull, f_rempty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0]  f_count;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(16), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.DATA_W(16), .DEPTH(8), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .winc(f_winc), .wdata(f_wdata), .rinc(f_rinc),
        .rdata(f_rdata), .rvalid(f_rvalid), .wfull(f_wfull), .rempty(f_rempty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] mq[$];
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    int          edge_n = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus the two sticky flags.
    task automatic model_edge(input logic w, input logic [15:0] wd, input logic r, input logic fl);
        int  n;
        logic racc, wacc;
        exp_t e;
        n = mq.size();
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            racc = r && (n != 0);
            wacc = w && ((n != 8) || racc);
            if (racc) begin
                e.data = mq.pop_front();
                e.due  = edge_n;
                expq.push_back(e);
            end
            if (wacc) mq.push_back(wd);
            if (w && !wacc) m_ovf = 1'b1;
            if (r && n == 0) m_udf = 1'b1;
        end
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        chk("status{count,wfull,rempty,af,ae,ovf,udf}",
            {22'd0, count, wfull, rempty, almost_full, almost_empty, overflow, underflow},
            {22'd0, 4'(n), n == 8, n == 0, n >= 6, n <= 2, m_ovf, m_udf});
    endtask

    task automatic step(input logic w, input logic [15:0] wd, input logic r, input logic fl);
        @(negedge clk);
        winc = w; wdata = wd; rinc = r; flush = fl;
        @(posedge clk);
        edge_n++;
        model_edge(w, wd, r, fl);
        #1;
        check_status();
    endtask

    // Monitor: every negedge either a scheduled pop is due and must be presented, or
    // the output must be idle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && edge_n > 0) begin
            if (expq.size() > 0 && expq[0].due == edge_n) begin
                e = expq.pop_front();
                chk("pop", {15'd0, rvalid, rdata}, {15'd0, 1'b1, e.data});
            end else begin
                chk("idle_out", {15'd0, rvalid, rdata}, 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        logic        w, r, fl;

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        check_status();
        chk("rst_rdata_rvalid", {15'd0, rvalid, rdata}, 32'd0);
        chk("fwft_rst", {14'd0, f_rvalid, f_rempty, f_rdata}, {14'd0, 2'b01, 16'h0000});
        @(negedge clk);
        rst = 1'b0;

        // Fill then drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // Write-through when full
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'hAAAA, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // Pointer wrap with interleaved pairs, then overflow and flush
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0);
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h6666, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Randomised traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
            r  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
            fl = ($urandom_range(0, 63) == 0);
            step(w, 16'($urandom), r, fl);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        // First-word-fall-through instance
        @(negedge clk);
        chk("fwft_pre_write", {15'd0, f_rvalid, f_rdata}, 32'd0);
        f_winc = 1'b1; f_wdata = 16'h1234;
        @(posedge clk); #1;
        chk("fwft_visible", {15'd0, f_rvalid, f_rdata}, {15'd0, 1'b1, 16'h1234});
        @(negedge clk);
        f_winc = 1'b0; f_rinc = 1'b1;
        @(posedge clk); #1;
        chk("fwft_pop", {14'd0, f_rempty, f_rvalid, f_rdata}, {14'd0, 2'b10, 16'h0000});
        chk("fwft_no_udf", {31'd0, f_udf}, 32'd0);
        @(posedge clk); #1;
        chk("fwft_udf", {31'd0, f_udf}, 32'd1);
        @(negedge clk);
        f_rinc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f_winc = 1'b1; f_wdata = 16'hC000 + 16'(i);
        end
        @(negedge clk);
        f_winc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fwft_head", {15'd0, f_rvalid, f_rdata}, {15'd0, 1'b1, 16'hC000 + 16'(i)});
            f_rinc = 1'b1;
            @(negedge clk);
        end
        f_rinc = 1'b0;
        chk("fwft_drained", {15'd0, f_rempty, f_count, 12'd0}, {15'd0, 1'b1, 4'd0, 12'd0});

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h0104, 1'b1, 1'b0);
        step(1'b1, 16'h0105, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        mq.delete();
        expq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_status();
        chk("async_rst_out", {15'd0, rvalid, rdata}, 32'd0);
        @(negedge clk);
        winc = 1'b0; rinc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO, successor to the fixed-type neighbour FIFO. It is generic in data width and depth, and adds:
- a first-word-fall-through (FWFT) mode
- occupancy count and programmable almost-full/almost-empty flags
- write-through-when-full, synchronous flush and sticky overflow/underflow error flags

It sits between producer/consumer stages (neighbour, feature-vector and request queues) and replaces per-type FIFO copies.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; must be a power of 2, >=2
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on rdata while not empty
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of pointers, count and error flags
winc  in  1  write request
wdata  in  DATA_W  write data
rinc  in  1  read request (pop)
rdata  out  DATA_W  read data
rvalid  out  1  rdata holds valid popped data (FWFT: equals ~rempty)
wfull  out  1  FIFO full
rempty  out  1  FIFO empty
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits. The low bits address storage; the MSB is the wrap bit.
  - rempty = (wr_ptr == rd_ptr)
  - wfull = MSBs differ and low bits equal
- count is a registered value equal to wr_ptr - rd_ptr (modulo 2^(AW+1)). All status flags are combinational from the registered pointers/count.
- Reset (rst=1, async): pointers=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0. Storage contents are not reset.
- rd_acc = rinc & ~rempty.
- wr_acc = winc & (~wfull | rd_acc). Write-through-when-full: a simultaneous read frees the slot in the same cycle, and count stays DEPTH.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- Read on empty is rejected even with a same-cycle write; there is no bypass. The write is still accepted.
- Pointers wrap naturally through 2*DEPTH; no special case.
- Registered mode (FWFT=0):
  - On rd_acc, rdata <= mem[rd_ptr] and rvalid <= 1 on the next edge.
  - Otherwise rdata <= 0 and rvalid <= 0. rvalid is a one-cycle pulse per pop.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] combinationally when ~rempty, else 0.
  - rvalid = ~rempty.
  - rinc pops the shown word at the edge. A word written at edge N is visible on rdata after edge N.
- overflow sets when winc & ~wr_acc. underflow sets when rinc & rempty. Both hold until rst or flush.
- flush: at the next edge, pointers=0, count=0, overflow=underflow=0, and (FWFT=0) rvalid=0 / rdata=0.
  - flush has priority over winc/rinc in the same cycle; those requests are dropped and do not set the error flags.
- Reset asserted mid-operation: all outputs go to reset values immediately (async). Data in flight is lost.
- Parameter checks are elaboration-time assertions: DEPTH power of 2; 0 < AEMPTY_TH < AFULL_TH <= DEPTH.

Decomposition:
- Shared package (fifo_pkg): width helper function for pointer/count widths and a status struct typedef {wfull, rempty, almost_full, almost_empty, overflow, underflow}. Typed payloads (e.g. Neighbor_info2Neighbor_FIFO) are carried by instantiating with DATA_W = $bits(type).
- One sub-module: param_sync_fifo_mem. Dual-port register array with synchronous write and two read styles: registered read (FWFT=0) and async read (FWFT=1).

Test Plan:
1. DEPTH=8, DATA_W=16, FWFT=0: write 0x0001..0x0008 -> wfull=1, count=8, almost_full=1. Then pop 8 -> rdata 0x0001..0x0008, each one cycle after rinc with an rvalid pulse. Finally rempty=1.
2. Full FIFO, winc=rinc=1 with wdata=0xAAAA for 4 cycles -> count stays 8, no overflow. Popped order continues 0x0001..0x0004, and 0xAAAA appears after the original 8 words.
3. Wrap: 20 interleaved write/read pairs -> pointers pass 2*DEPTH and data order is preserved. Then, on a full FIFO with rinc=0, winc=1 -> overflow=1 and remains set. Next, flush=1 -> count=0, overflow=0.
4. FWFT=1: write 0x1234 at edge N -> rdata=0x1234 and rvalid=1 after edge N. rinc=1 -> rempty=1 and rdata=0 next cycle. A further rinc sets underflow=1.
5. Thresholds AFULL_TH=6, AEMPTY_TH=2: fill 0->8 -> almost_empty deasserts at count=3 and almost_full asserts at count=6. Drain: almost_full drops at count=5 and almost_empty rises at count=2.
6. Assert rst asynchronously mid-burst (count=5, FWFT=0) between edges -> all outputs immediately at reset values. After release, a first write of 0x00FF followed by a read returns 0x00FF.
